// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: turns each rising edge of the neuron spike line into an event,
// stretches events into an LED pulse and publishes a saturated per-window event count.
module spike_rate_monitor #(
    parameter int WINDOW  = 1000,
    parameter int CNT_W   = 8,
    parameter int STRETCH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_in,
    input  logic             en,
    output logic             led_out,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic             overflow
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int STR_W = $clog2(STRETCH + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH);
    localparam logic [STR_W-1:0] STR_ONE  = STR_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             spike_q;
    logic             evt;
    logic [STR_W-1:0] str_cnt;
    logic [STR_W-1:0] str_next;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt;
    logic [CNT_W-1:0] spk_next;
    logic             sat_flag;
    logic             sat_hit;
    logic             win_last;
    logic             win_clear;
    logic             win_publish;
    logic             win_advance;

    // ------------------------------------------------------------------
    // Edge detect: a held level is a single event; the first high cycle
    // after reset counts because spike_q starts low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike_in;
        end
    end

    assign evt = spike_in & ~spike_q;

    // ------------------------------------------------------------------
    // LED stretcher, runs regardless of en. led_out mirrors the next
    // counter value so the LED rises on the edge that samples evt.
    // ------------------------------------------------------------------
    always_comb begin
        str_next = str_cnt;
        if (evt) begin
            str_next = STR_LOAD;
        end else if (str_cnt != '0) begin
            str_next = str_cnt - STR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            str_cnt <= '0;
            led_out <= 1'b0;
        end else begin
            str_cnt <= str_next;
            led_out <= (str_next != '0);
        end
    end

    // ------------------------------------------------------------------
    // Window FSM: state register, next-state logic, output decode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (en)  state_next = RUN;
            RUN:  if (!en) state_next = IDLE;
            default:       state_next = IDLE;
        endcase
    end

    assign win_last = (win_cnt == WIN_LAST);

    // en=0 takes priority over publishing, so a window closed by en=0 is dropped.
    always_comb begin
        win_clear   = 1'b1;
        win_publish = 1'b0;
        win_advance = 1'b0;
        if (state == RUN && en) begin
            win_clear   = 1'b0;
            win_publish = win_last;
            win_advance = ~win_last;
        end
    end

    // ------------------------------------------------------------------
    // Window datapath: saturating event counter and publish registers.
    // ------------------------------------------------------------------
    assign sat_hit  = evt && (spk_cnt == CNT_MAX);
    assign spk_next = sat_hit ? spk_cnt : spk_cnt + {{(CNT_W-1){1'b0}}, evt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt    <= '0;
            spk_cnt    <= '0;
            sat_flag   <= 1'b0;
            rate       <= '0;
            rate_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (win_clear) begin
                win_cnt  <= '0;
                spk_cnt  <= '0;
                sat_flag <= 1'b0;
            end else if (win_publish) begin
                rate       <= spk_next;
                overflow   <= sat_flag | sat_hit;
                rate_valid <= 1'b1;
                win_cnt    <= '0;
                spk_cnt    <= '0;
                sat_flag   <= 1'b0;
            end else if (win_advance) begin
                win_cnt  <= win_cnt + WIN_ONE;
                spk_cnt  <= spk_next;
                sat_flag <= sat_flag | sat_hit;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor: a 16-cycle/8-bit instance for stretch, windowing
// and enable handling, and a 32-cycle/3-bit instance for counter saturation.
module tb_spike_rate_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spike = 1'b0;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;

    logic       led_a, va, oa;
    logic [7:0] ra;
    logic       led_b, vb, ob;
    logic [2:0] rb;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    spike_rate_monitor #(.WINDOW(16), .CNT_W(8), .STRETCH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .spike_in(spike), .en(en_a),
        .led_out(led_a), .rate(ra), .rate_valid(va), .overflow(oa)
    );

    spike_rate_monitor #(.WINDOW(32), .CNT_W(3), .STRETCH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .spike_in(spike), .en(en_b),
        .led_out(led_b), .rate(rb), .rate_valid(vb), .overflow(ob)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one window worth of spike levels, one bit per cycle, starting at win_cnt=0.
    task automatic run_window(input bit use_b, input int len, input logic [31:0] pat);
        int early;
        early = 0;
        for (int i = 0; i < len; i++) begin
            spike = pat[i];
            step();
            if (i < len - 1 && (use_b ? vb : va)) early++;
        end
        spike = 1'b0;
        check(use_b ? "b_valid_early" : "a_valid_early", early, 0);
        check(use_b ? "b_valid_end" : "a_valid_end", use_b ? vb : va, 1);
    endtask

    // scoreboard for dut_a published rates
    always @(negedge clk) begin
        if (rst_n && va) begin
            if (exp_q.size() == 0) check("a_unexpected_valid", 1, 0);
            else check("a_rate", ra, exp_q.pop_front());
        end
    end

    initial begin
        int n;

        // reset state
        step();
        step();
        check("rst_led", led_a, 0);
        check("rst_rate", ra, 0);
        check("rst_valid", va, 0);
        check("rst_ovf", oa, 0);
        check("rst_b_rate", rb, 0);
        rst_n = 1'b1;
        step();

        // single event: LED rises on the sampling edge, high 4 cycles
        spike = 1'b1;
        step();
        check("led_rise", led_a, 1);
        spike = 1'b0;
        n = 1;
        repeat (8) begin step(); n += int'(led_a); end
        check("led_len_single", n, 4);

        // retrigger two cycles after the first event: 2 + 4 = 6 cycles
        spike = 1'b1;
        step();
        spike = 1'b0;
        step();
        spike = 1'b1;
        step();
        spike = 1'b0;
        n = 3;
        repeat (10) begin step(); n += int'(led_a); end
        check("led_len_retrig", n, 6);

        // held level is one event
        spike = 1'b1;
        n = 0;
        repeat (10) begin step(); n += int'(led_a); end
        spike = 1'b0;
        repeat (6) begin step(); n += int'(led_a); end
        check("led_len_held", n, 4);

        // windows back to back: held 10 cycles, 5 spikes incl. final cycle, then 2
        en_a = 1'b1;
        step();
        exp_q.push_back(8'd1);
        run_window(1'b0, 16, 32'h0000_03FF);
        exp_q.push_back(8'd5);
        run_window(1'b0, 16, 32'h0000_80AA);
        check("a_ovf_clear", oa, 0);
        exp_q.push_back(8'd2);
        run_window(1'b0, 16, 32'h0000_0012);

        // async reset mid-run with LED lit
        spike = 1'b1;
        step();
        check("pre_rst_led", led_a, 1);
        rst_n = 1'b0;
        #2;
        check("async_rst_led", led_a, 0);
        check("async_rst_rate", ra, 0);
        check("async_rst_valid", va, 0);
        check("async_rst_ovf", oa, 0);
        spike = 1'b0;
        en_a = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // saturation on the 3-bit instance, then a clean window
        en_b = 1'b1;
        step();
        run_window(1'b1, 32, 32'h0005_5555);
        check("b_rate_sat", rb, 7);
        check("b_ovf_set", ob, 1);
        run_window(1'b1, 32, 32'h0000_0044);
        check("b_rate_next", rb, 2);
        check("b_ovf_clear", ob, 0);
        en_b = 1'b0;
        step();

        // en dropped at win_cnt==8: partial window discarded, rate holds
        en_a = 1'b1;
        step();
        exp_q.push_back(8'd2);
        run_window(1'b0, 16, 32'h0000_0101);
        for (int i = 0; i < 8; i++) begin
            spike = (i == 3);
            step();
        end
        spike = 1'b0;
        en_a = 1'b0;
        step();
        n = 0;
        repeat (20) begin step(); n += int'(va); end
        check("a_no_valid_drop", n, 0);
        check("a_rate_hold", ra, 2);

        // re-enable gives a fresh full window
        en_a = 1'b1;
        step();
        exp_q.push_back(8'd1);
        run_window(1'b0, 16, 32'h0000_0008);

        // en=0 on the final window cycle wins over publishing
        for (int i = 0; i < 15; i++) begin
            spike = (i == 5);
            step();
        end
        spike = 1'b0;
        en_a = 1'b0;
        step();
        n = 0;
        repeat (20) begin step(); n += int'(va); end
        check("a_no_valid_final_drop", n, 0);
        check("a_rate_hold_final", ra, 1);

        step();
        check("a_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
